// File: rtl/da_pkg.sv
// Shared state encoding and default parameters for the serial DAC writer.
package da_pkg;

    localparam int unsigned DA_CLK_DIV = 20;
    localparam int unsigned DA_DATA_W  = 10;
    localparam int unsigned DA_FRAME_W = 12;
    localparam int unsigned DA_CS_GAP  = 2;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } state_t;

endpackage

// File: rtl/da_tick_gen.sv
// Half-period tick generator; counts 0..CLK_DIV-1 while enabled, tick on the last count.
module da_tick_gen #(
    parameter int unsigned CLK_DIV = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] div_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (clr) begin
            div_cnt <= '0;
        end else if (en) begin
            div_cnt <= (div_cnt == LAST) ? '0 : div_cnt + CNT_W'(1);
        end
    end

    assign tick = en && (div_cnt == LAST);

endmodule

// File: rtl/da_serial_tx.sv
// Serial DAC writer: takes a parallel sample over valid/ready and shifts one
// chip-selected frame out MSB first, data changing only on daclk falling edges.
module da_serial_tx
    import da_pkg::*;
#(
    parameter int unsigned CLK_DIV = DA_CLK_DIV,
    parameter int unsigned DATA_W  = DA_DATA_W,
    parameter int unsigned FRAME_W = DA_FRAME_W,
    parameter int unsigned CS_GAP  = DA_CS_GAP
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              din_valid,
    input  logic [DATA_W-1:0] din,
    output logic              din_ready,
    output logic              dacs,
    output logic              daclk,
    output logic              dadata,
    output logic              isdone,
    output logic              busy
);

    if (CLK_DIV < 2 || FRAME_W < DATA_W || FRAME_W < 2 || CS_GAP < 1) begin : g_param_check
        $error("da_serial_tx: invalid CLK_DIV/FRAME_W/DATA_W/CS_GAP combination");
    end

    // bit_cnt doubles as the half-period counter in HOLD and GAP
    localparam int unsigned BC_MAX = (FRAME_W > CS_GAP) ? FRAME_W : CS_GAP;
    localparam int unsigned BC_W   = (BC_MAX > 2) ? $clog2(BC_MAX) : 1;

    state_t             state, state_n;
    logic [FRAME_W-1:0] shreg, shreg_n;
    logic [BC_W-1:0]    bit_cnt, bit_cnt_n;
    logic               dacs_n, daclk_n, dadata_n, isdone_n, din_ready_n;
    logic               tick;
    logic               accept;

    assign accept = din_valid && din_ready;

    da_tick_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_tick (
        .clk (clk),
        .rst (rst),
        .en  (state != IDLE),
        .clr (accept),
        .tick(tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            shreg     <= '0;
            bit_cnt   <= '0;
            dacs      <= 1'b1;
            daclk     <= 1'b0;
            dadata    <= 1'b0;
            isdone    <= 1'b0;
            din_ready <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            shreg     <= shreg_n;
            bit_cnt   <= bit_cnt_n;
            dacs      <= dacs_n;
            daclk     <= daclk_n;
            dadata    <= dadata_n;
            isdone    <= isdone_n;
            din_ready <= din_ready_n;
            busy      <= (state_n != IDLE);
        end
    end

    always_comb begin
        state_n     = state;
        shreg_n     = shreg;
        bit_cnt_n   = bit_cnt;
        dacs_n      = dacs;
        daclk_n     = daclk;
        dadata_n    = dadata;
        isdone_n    = 1'b0;
        din_ready_n = din_ready;

        case (state)
            IDLE: begin
                din_ready_n = 1'b1;
                if (accept) begin
                    shreg_n     = FRAME_W'(din) << (FRAME_W - DATA_W);
                    dacs_n      = 1'b0;
                    dadata_n    = din[DATA_W-1];
                    din_ready_n = 1'b0;
                    state_n     = SETUP;
                end
            end
            SETUP: begin
                if (tick) begin
                    daclk_n   = 1'b1;
                    bit_cnt_n = BC_W'(FRAME_W - 1);
                    state_n   = SHIFT;
                end
            end
            SHIFT: begin
                if (tick) begin
                    daclk_n = ~daclk;
                    if (daclk) begin
                        if (bit_cnt != '0) begin
                            shreg_n   = shreg << 1;
                            dadata_n  = shreg[FRAME_W-2];
                            bit_cnt_n = bit_cnt - BC_W'(1);
                        end else begin
                            // HOLD spans the last low phase plus one CS hold half-period
                            dadata_n  = 1'b0;
                            bit_cnt_n = BC_W'(1);
                            state_n   = HOLD;
                        end
                    end
                end
            end
            HOLD: begin
                if (tick) begin
                    if (bit_cnt == '0) begin
                        dacs_n    = 1'b1;
                        isdone_n  = 1'b1;
                        bit_cnt_n = BC_W'(CS_GAP - 1);
                        state_n   = GAP;
                    end else begin
                        bit_cnt_n = bit_cnt - BC_W'(1);
                    end
                end
            end
            GAP: begin
                if (tick) begin
                    if (bit_cnt == '0) begin
                        din_ready_n = 1'b1;
                        state_n     = IDLE;
                    end else begin
                        bit_cnt_n = bit_cnt - BC_W'(1);
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule
